// File: rtl/ascon_pkg.sv
// Shared types and constants for the bit-sliced Ascon feeder.
package ascon_pkg;

    localparam int unsigned LANE_W  = 64;
    localparam int unsigned CONST_W = 8;
    localparam int unsigned CNT_W   = $clog2(LANE_W);
    localparam int unsigned CIDX_W  = $clog2(CONST_W);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} ser_state_t;

    typedef logic [LANE_W-1:0] lane_t;

    // Upper nibble counts down while the lower nibble counts up with the round number.
    function automatic logic [CONST_W-1:0] round_const(input logic [3:0] r);
        logic [3:0] hi;
        hi = 4'd15 - r;
        return {hi, r};
    endfunction

endpackage

// File: rtl/ascon_lane_shift_reg.sv
// One state word: parallel load, shift left by one per cycle, serial MSB out.
module ascon_lane_shift_reg
    import ascon_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  shift,
    input  lane_t din,
    output logic  msb
);

    lane_t lane_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q <= '0;
        end else if (load) begin
            lane_q <= din;
        end else if (shift) begin
            lane_q <= {lane_q[LANE_W-2:0], 1'b0};
        end
    end

    assign msb = lane_q[LANE_W-1];

endmodule

// File: rtl/ascon_state_serializer.sv
// Streams the 320-bit Ascon initial state one bit-slice per cycle and paces the
// round windows (round-constant bit, start strobe, done) for a bit-sliced permutation core.
module ascon_state_serializer
    import ascon_pkg::*;
#(
    parameter int unsigned ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [63:0]  iv,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    output logic [4:0]   input_data,
    output logic         constant,
    output logic         start_permutation,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    ser_state_t         state;
    logic [CNT_W-1:0]   bit_cnt;

    logic               accept;
    logic               shift_en;
    lane_t              lane_in [5];
    logic [4:0]         lane_msb;

    logic               last_bit;
    logic               last_win;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [3:0]         idx_nxt;
    logic [CONST_W-1:0] rc_nxt;
    logic               const_nxt;

    assign accept   = load_valid && (state == IDLE);
    assign shift_en = (state == LOAD);

    assign lane_in[0] = iv;
    assign lane_in[1] = key[127:64];
    assign lane_in[2] = key[63:0];
    assign lane_in[3] = nonce[127:64];
    assign lane_in[4] = nonce[63:0];

    for (genvar i = 0; i < 5; i++) begin : g_lane
        ascon_lane_shift_reg u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (accept),
            .shift (shift_en),
            .din   (lane_in[i]),
            .msb   (lane_msb[4-i])
        );
    end

    // Lanes drain to zero during window 0, so later windows present zero slices.
    assign input_data = lane_msb;

    // Look one cycle ahead so the constant register lines up with the slice it belongs to.
    always_comb begin
        last_bit  = (bit_cnt == '0);
        last_win  = (round_idx == 4'(ROUNDS - 1));
        cnt_nxt   = last_bit ? CNT_W'(LANE_W - 1) : bit_cnt - CNT_W'(1);
        idx_nxt   = last_bit ? round_idx + 4'd1 : round_idx;
        rc_nxt    = round_const(4'(12 - ROUNDS) + idx_nxt);
        const_nxt = (cnt_nxt < CNT_W'(CONST_W)) ? rc_nxt[cnt_nxt[CIDX_W-1:0]] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            bit_cnt           <= '0;
            round_idx         <= '0;
            constant          <= 1'b0;
            start_permutation <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            load_ready        <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state             <= LOAD;
                        bit_cnt           <= CNT_W'(LANE_W - 1);
                        round_idx         <= '0;
                        constant          <= 1'b0;
                        start_permutation <= 1'b1;
                        busy              <= 1'b1;
                        load_ready        <= 1'b0;
                    end
                end
                LOAD, ROUND: begin
                    if (last_bit && last_win) begin
                        state             <= DONE;
                        constant          <= 1'b0;
                        start_permutation <= 1'b0;
                        busy              <= 1'b0;
                        done              <= 1'b1;
                    end else begin
                        bit_cnt   <= cnt_nxt;
                        round_idx <= idx_nxt;
                        constant  <= const_nxt;
                        if (last_bit) begin
                            state <= ROUND;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    round_idx  <= '0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_state_serializer.sv
// Scoreboard bench: expected per-cycle output records are queued at accept and
// checked cycle by cycle by an independent monitor.
module tb_ascon_state_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_valid = 1'b0;
    logic [63:0]  iv = '0;
    logic [127:0] key = '0;
    logic [127:0] nonce = '0;

    logic         load_ready;
    logic [4:0]   input_data;
    logic         constant;
    logic         start_permutation;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    // Index 0: ROUNDS=6, index 1: ROUNDS=1.
    logic [1:0]       lr_s;
    logic [1:0][4:0]  din_s;
    logic [1:0]       con_s;
    logic [1:0]       sp_s;
    logic [1:0][3:0]  ri_s;
    logic [1:0]       busy_s;
    logic [1:0]       done_s;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [13:0] val;
        logic [13:0] mask;
    } sb_item_t;

    sb_item_t exp_q [$];
    sb_item_t mon_e;

    logic [7:0] rc12 [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    localparam logic [63:0]  IV1    = 64'h8040_0c06_0000_0000;
    localparam logic [127:0] KEY1   = 128'h0001_0203_0405_0607_0809_0a0b_1215_3524;
    localparam logic [127:0] NONCE1 = 128'hffff_0000_1111_2222_8888_4444_c089_5e81;
    localparam logic [63:0]  IV2    = 64'h0123_4567_89ab_cdef;
    localparam logic [127:0] KEY2   = 128'hdead_beef_cafe_f00d_5a5a_a5a5_3c3c_c3c3;
    localparam logic [127:0] NONCE2 = 128'h7fff_0001_8000_fffe_1357_9bdf_2468_ace0;

    logic [13:0] obs;
    assign obs = {input_data, constant, start_permutation, round_idx, busy, done, load_ready};

    always #5 clk = ~clk;

    ascon_state_serializer #(.ROUNDS(12)) dut (
        .clk               (clk),
        .rst               (rst),
        .load_valid        (load_valid),
        .load_ready        (load_ready),
        .iv                (iv),
        .key               (key),
        .nonce             (nonce),
        .input_data        (input_data),
        .constant          (constant),
        .start_permutation (start_permutation),
        .round_idx         (round_idx),
        .busy              (busy),
        .done              (done)
    );

    ascon_state_serializer #(.ROUNDS(6)) dut6 (
        .clk               (clk),
        .rst               (rst),
        .load_valid        (load_valid),
        .load_ready        (lr_s[0]),
        .iv                (iv),
        .key               (key),
        .nonce             (nonce),
        .input_data        (din_s[0]),
        .constant          (con_s[0]),
        .start_permutation (sp_s[0]),
        .round_idx         (ri_s[0]),
        .busy              (busy_s[0]),
        .done              (done_s[0])
    );

    ascon_state_serializer #(.ROUNDS(1)) dut1 (
        .clk               (clk),
        .rst               (rst),
        .load_valid        (load_valid),
        .load_ready        (lr_s[1]),
        .iv                (iv),
        .key               (key),
        .nonce             (nonce),
        .input_data        (din_s[1]),
        .constant          (con_s[1]),
        .start_permutation (sp_s[1]),
        .round_idx         (ri_s[1]),
        .busy              (busy_s[1]),
        .done              (done_s[1])
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected stream for ROUNDS=12: 768 window cycles then the done cycle.
    task automatic push_stream(input logic [63:0] v_iv, input logic [127:0] v_key,
                               input logic [127:0] v_nonce);
        sb_item_t it;
        for (int c = 0; c < 768; c++) begin
            int w;
            int b;
            w = c / 64;
            b = 63 - (c % 64);
            it.val  = '0;
            it.mask = '1;
            if (w == 0) begin
                it.val[13:9] = {v_iv[b], v_key[64+b], v_key[b], v_nonce[64+b], v_nonce[b]};
            end
            it.val[8]   = (b < 8) ? rc12[w][b] : 1'b0;
            it.val[7]   = 1'b1;
            it.val[6:3] = w[3:0];
            it.val[2]   = 1'b1;
            exp_q.push_back(it);
        end
        it.val  = 14'h0002;
        it.mask = 14'h3f87;
        exp_q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                cmp("stream", 64'(obs & mon_e.mask), 64'(mon_e.val & mon_e.mask));
            end else if (start_permutation || done) begin
                cmp("unexpected_output", 64'({start_permutation, done}), 64'd0);
            end
        end
    end

    task automatic start_stream(input logic [63:0] v_iv, input logic [127:0] v_key,
                                input logic [127:0] v_nonce);
        @(negedge clk);
        iv         = v_iv;
        key        = v_key;
        nonce      = v_nonce;
        load_valid = 1'b1;
        cmp("ready_before_accept", 64'(load_ready), 64'd1);
        @(posedge clk);
        push_stream(v_iv, v_key, v_nonce);
    endtask

    task automatic follow_stream(input bit hold, input bit toggle, output logic [4:0] first);
        int  lat;
        int  starts;
        bit  found;
        lat    = 0;
        starts = 0;
        found  = 1'b0;
        first  = '0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                first = input_data;
                if (!hold) load_valid = 1'b0;
            end
            if (start_permutation) starts++;
            if (done) begin
                lat   = c;
                found = 1'b1;
                if (toggle) load_valid = 1'b0;
                break;
            end
            if (toggle && c > 1) begin
                load_valid = (c % 3 == 0);
                iv         = {$urandom, $urandom};
                key        = {$urandom, $urandom, $urandom, $urandom};
                nonce      = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        cmp("done_seen", 64'(found), 64'd1);
        cmp("done_latency", 64'(lat), 64'd769);
        cmp("start_cycles", 64'(starts), 64'd768);
        @(negedge clk);
        cmp("ready_after_done", 64'(load_ready), 64'd1);
        cmp("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_small(input int idx, input logic [7:0] rc_exp, input int lat_exp);
        logic [63:0] w0;
        int          lat;
        w0  = '0;
        lat = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c <= 64) w0 = {w0[62:0], con_s[idx]};
            if (done_s[idx]) begin
                lat = c;
                break;
            end
        end
        cmp(idx == 0 ? "r6_window0_const" : "r1_window0_const", w0, {56'd0, rc_exp});
        cmp(idx == 0 ? "r6_done_latency" : "r1_done_latency", 64'(lat), 64'(lat_exp));
    endtask

    initial begin
        logic [4:0] first;
        int         done_cnt;

        // Reset held for 10 cycles.
        repeat (10) @(posedge clk);
        @(negedge clk);
        cmp("reset_outputs", 64'(obs), 64'h0001);
        cmp("reset_r6", 64'({lr_s[0], din_s[0], con_s[0], sp_s[0], ri_s[0], busy_s[0], done_s[0]}),
            64'h2000);
        cmp("reset_r1", 64'({lr_s[1], din_s[1], con_s[1], sp_s[1], ri_s[1], busy_s[1], done_s[1]}),
            64'h2000);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reference vector, all three instances accept together.
        start_stream(IV1, KEY1, NONCE1);
        fork
            follow_stream(1'b0, 1'b0, first);
            check_small(0, 8'h96, 385);
            check_small(1, 8'h4b, 65);
        join
        cmp("first_slice", 64'(first), 64'h13);

        // load_valid toggled with junk data while busy.
        repeat (3) @(negedge clk);
        start_stream(IV2, KEY2, NONCE2);
        follow_stream(1'b0, 1'b1, first);

        // load_valid held high: back-to-back accepts.
        repeat (3) @(negedge clk);
        start_stream(IV1, KEY1, NONCE1);
        follow_stream(1'b1, 1'b0, first);
        @(posedge clk);
        push_stream(IV1, KEY1, NONCE1);
        follow_stream(1'b0, 1'b0, first);
        cmp("reaccept_first_slice", 64'(first), 64'h13);

        // Let the other instances finish any stream they picked up while load_valid was held.
        repeat (800) @(negedge clk);

        // Asynchronous reset in the middle of window 0.
        start_stream(IV2, KEY2, NONCE2);
        @(negedge clk);
        load_valid = 1'b0;
        repeat (19) @(negedge clk);
        #2;
        exp_q.delete();
        rst = 1'b0;
        #1;
        cmp("async_reset_outputs", 64'(obs), 64'h0001);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (done || (|done_s)) done_cnt++;
        end
        cmp("no_partial_done", 64'(done_cnt), 64'd0);
        cmp("idle_after_reset", 64'(obs), 64'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
